// File: rtl/polar_clip_mul_arbiter.sv
// Round-robin arbiter sharing one 3-stage signed 16x16 multiplier among NUM_REQ requesters.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high; the whole pipeline stalls while res_valid && !res_ready.
module polar_clip_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [16*NUM_REQ-1:0]  req_a,
  input  logic [16*NUM_REQ-1:0]  req_b,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [ID_W-1:0]        res_id,
  output logic [31:0]            res_data,
  output logic                   busy
);

  logic                w_ce;
  logic                w_found;
  logic [ID_W-1:0]     w_grant;
  logic signed [15:0]  w_a;
  logic signed [15:0]  w_b;
  logic signed [31:0]  w_prod;

  logic [ID_W-1:0]     r_last;
  logic signed [15:0]  r_a;
  logic signed [15:0]  r_b;
  logic signed [31:0]  r_p2;
  logic signed [31:0]  r_p3;
  logic                r_v1;
  logic                r_v2;
  logic                r_v3;
  logic [ID_W-1:0]     r_id1;
  logic [ID_W-1:0]     r_id2;
  logic [ID_W-1:0]     r_id3;

  assign w_ce = !r_v3 || res_ready;

  // First pass looks above r_last, second pass wraps around to the lowest index.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && req_valid[i] && (ID_W'(i) > r_last)) begin
        w_found = 1'b1;
        w_grant = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && req_valid[i]) begin
        w_found = 1'b1;
        w_grant = ID_W'(i);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = !reset && w_ce && w_found && (w_grant == ID_W'(i));
    end
  end

  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant == ID_W'(i)) begin
        w_a = req_a[16*i +: 16];
        w_b = req_b[16*i +: 16];
      end
    end
  end

  assign w_prod = $signed({{16{r_a[15]}}, r_a}) * $signed({{16{r_b[15]}}, r_b});

  // Every stage, bubbles included, moves only on w_ce so nothing is lost under backpressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last <= ID_W'(NUM_REQ - 1);
      r_a    <= '0;
      r_b    <= '0;
      r_p2   <= '0;
      r_p3   <= '0;
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_v3   <= 1'b0;
      r_id1  <= '0;
      r_id2  <= '0;
      r_id3  <= '0;
    end else if (w_ce) begin
      r_v1  <= w_found;
      r_id1 <= w_grant;
      r_a   <= w_a;
      r_b   <= w_b;
      r_v2  <= r_v1;
      r_id2 <= r_id1;
      r_p2  <= w_prod;
      r_v3  <= r_v2;
      r_id3 <= r_id2;
      r_p3  <= r_p2;
      if (w_found) begin
        r_last <= w_grant;
      end
    end
  end

  assign res_valid = r_v3;
  assign res_id    = r_id3;
  assign res_data  = r_p3;
  assign busy      = r_v1 || r_v2 || r_v3;

endmodule

// File: tb/tb_polar_clip_mul_arbiter.sv
// Directed bench for polar_clip_mul_arbiter: vector table plus latency, round-robin,
// backpressure, mid-flight reset and sparse-priority sequences.
module tb_polar_clip_mul_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        res_valid;
  logic        res_ready;
  logic [1:0]  res_id;
  logic [31:0] res_data;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          id;
    int          a;
    int          b;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[6];
  logic [33:0] exp_q[$];

  polar_clip_mul_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_data  (res_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_op(input int i, input int a, input int b);
    req_a[16*i +: 16] = 16'(a);
    req_b[16*i +: 16] = 16'(b);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    req_valid = '0;
    res_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [33:0] e;
    logic [31:0] prev_data;
    logic [1:0]  prev_id;
    logic        stalled_prev;
    int          j;
    int          got;
    int          a_i;
    int          b_i;

    vecs[0] = '{2,    300,     -7, 32'hFFFFF7CC};
    vecs[1] = '{0, -32768, -32768, 32'h40000000};
    vecs[2] = '{1,  32767, -32768, 32'hC0008000};
    vecs[3] = '{3,     -1,      1, 32'hFFFFFFFF};
    vecs[4] = '{1,    123,    456, 32'h0000DB18};
    vecs[5] = '{3,     -5,     -6, 32'h0000001E};

    // Reset: req_ready forced low while reset is high, then clean outputs.
    reset     = 1'b1;
    req_valid = '1;
    res_ready = 1'b1;
    req_a     = '0;
    req_b     = '0;
    @(negedge clk);
    #2 check("rst_req_ready", req_ready, 32'h0);
    @(negedge clk);
    reset     = 1'b0;
    req_valid = '0;
    #2;
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_id", res_id, 0);
    check("rst_busy", busy, 0);

    // Table: single requests, 3-cycle latency and busy high for exactly 3 cycles.
    for (int v = 0; v < 6; v++) begin
      @(negedge clk);
      set_op(vecs[v].id, vecs[v].a, vecs[v].b);
      req_valid = 4'(1 << vecs[v].id);
      #2 check("vec_req_ready", req_ready, 32'(1 << vecs[v].id));
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        req_valid = '0;
        #2;
        check("vec_busy", busy, (k <= 3) ? 1 : 0);
        check("vec_res_valid", res_valid, (k == 3) ? 1 : 0);
        if (k == 3) begin
          check("vec_res_data", res_data, vecs[v].exp_data);
          check("vec_res_id", res_id, 32'(vecs[v].id));
        end
      end
    end

    // Round-robin with all requesters valid.
    do_reset();
    for (int i = 0; i < 4; i++) set_op(i, i + 1, 10);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      req_valid = '1;
      #2;
      check("rr_grant", req_ready, 32'(1 << (c % 4)));
      if (c >= 3) begin
        check("rr_res_valid", res_valid, 1);
        check("rr_res_id", res_id, 32'((c - 3) % 4));
        check("rr_res_data", res_data, 32'(10 * ((c - 3) % 4 + 1)));
      end
    end
    @(negedge clk);
    req_valid = '0;
    repeat (5) @(negedge clk);
    #2 check("rr_drain_busy", busy, 0);

    // Backpressure: 6 requests, res_ready low for 5 cycles midway.
    for (int k = 0; k < 6; k++) begin
      a_i = k * 1000 - 2500;
      b_i = 7 - 3 * k;
      exp_q.push_back({2'(k % 4), 32'(a_i * b_i)});
    end
    j = 0;
    got = 0;
    stalled_prev = 1'b0;
    prev_data = '0;
    prev_id = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      res_ready = !(c >= 4 && c <= 8);
      if (j < 6) begin
        set_op(j % 4, j * 1000 - 2500, 7 - 3 * j);
        req_valid = 4'(1 << (j % 4));
      end else begin
        req_valid = '0;
      end
      #2;
      if (res_valid && !res_ready) begin
        check("bp_stall_req_ready", req_ready, 0);
        if (stalled_prev) begin
          check("bp_stall_data", res_data, prev_data);
          check("bp_stall_id", res_id, 32'(prev_id));
        end
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          check("bp_extra_product", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("bp_res_id", res_id, 32'(e[33:32]));
          check("bp_res_data", res_data, e[31:0]);
          got++;
        end
      end
      if (j < 6 && req_ready[j % 4]) j++;
      stalled_prev = res_valid && !res_ready;
      prev_data = res_data;
      prev_id = res_id;
      if (got == 6) break;
    end
    req_valid = '0;
    res_ready = 1'b1;
    check("bp_count", got, 6);
    check("bp_queue_empty", exp_q.size(), 0);
    repeat (4) @(negedge clk);
    #2 check("bp_idle_busy", busy, 0);

    // Reset with three products in flight.
    for (int i = 0; i < 4; i++) set_op(i, i + 1, 10);
    @(negedge clk);
    req_valid = '1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #2;
    check("mr_pre_res_valid", res_valid, 1);
    check("mr_req_ready_in_reset", req_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    #2;
    check("mr_res_valid", res_valid, 0);
    check("mr_busy", busy, 0);
    check("mr_first_grant", req_ready, 32'h1);
    @(negedge clk);
    req_valid = '0;
    #2 check("mr_no_stale_1", res_valid, 0);
    @(negedge clk);
    #2 check("mr_no_stale_2", res_valid, 0);
    @(negedge clk);
    #2;
    check("mr_new_valid", res_valid, 1);
    check("mr_new_id", res_id, 0);
    check("mr_new_data", res_data, 32'd10);
    @(negedge clk);
    #2;
    check("mr_end_valid", res_valid, 0);
    check("mr_end_busy", busy, 0);

    // Sparse priority: last=1, requesters 0 and 3 valid -> 3 then 0.
    @(negedge clk);
    set_op(1, 2, 2);
    req_valid = 4'b0010;
    #2 check("sp_setup_grant", req_ready, 32'h2);
    @(negedge clk);
    req_valid = '0;
    repeat (4) @(negedge clk);
    #2 check("sp_setup_idle", busy, 0);
    @(negedge clk);
    set_op(3, 7, -3);
    set_op(0, -9, 9);
    req_valid = 4'b1001;
    #2 check("sp_grant_3", req_ready, 32'h8);
    @(negedge clk);
    req_valid = 4'b0001;
    #2 check("sp_grant_0", req_ready, 32'h1);
    @(negedge clk);
    req_valid = '0;
    #2 check("sp_not_yet", res_valid, 0);
    @(negedge clk);
    #2;
    check("sp_res3_valid", res_valid, 1);
    check("sp_res3_id", res_id, 3);
    check("sp_res3_data", res_data, 32'hFFFFFFEB);
    @(negedge clk);
    #2;
    check("sp_res0_valid", res_valid, 1);
    check("sp_res0_id", res_id, 0);
    check("sp_res0_data", res_data, 32'hFFFFFFAF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
